jtag_tap_ctrl: RTL

//  IEEE 1149.1-style TAP controller sequencing the JTAG example's IR/DR datapath.

---
 rtl/jtag_pkg.sv | 33 +++
 rtl/jtag_sync_edge.sv | 28 ++
 rtl/jtag_tap_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction codes and the 1149.1 next-state rule.
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_t;
  localparam logic [3:0] INSTR_IDCODE = 4'b0001;
  localparam logic [3:0] INSTR_USER   = 4'b1000;
  localparam logic [3:0] INSTR_BYPASS = 4'b1111;
  localparam logic [1:0] IR_CAPTURE   = 2'b01;
  function automatic tap_state_t tap_next(tap_state_t s, logic tms);
    case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
      default:  return tms ? SEL_DR   : RTI;
    endcase
  endfunction
endpackage

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: multi-flop synchronizer for an edge-detected input plus a plain data bus.
module jtag_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise,
  output logic             fall
);
  logic [STAGES-1:0][WIDTH:0] ff;
  logic e_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
      e_d <= 1'b0;
    end else begin
      ff <= {ff[STAGES-2:0], {d, e}};
      e_d <= ff[STAGES-1][0];
    end
  end
  assign q = ff[STAGES-1][WIDTH:1];
  assign rise = ff[STAGES-1][0] & ~e_d;
  assign fall = ~ff[STAGES-1][0] & e_d;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: oversampled 1149.1 TAP with IDCODE, USER and BYPASS data registers.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF0FF,
  parameter int USER_DR_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tck,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_dr_update
);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(INSTR_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER = IR_WIDTH'(INSTR_USER);
  logic [1:0] pins_s;
  logic tck_rise, tck_fall, tms_s, tdi_s, is_id, is_user;
  tap_state_t state, nxt;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0] dr_sr, dr_cap, dr_shift;
  jtag_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync (
    .clk(clk), .rst_n(rst_n), .e(tck), .d({tdi, tms}), .q(pins_s),
    .rise(tck_rise), .fall(tck_fall)
  );
  assign tms_s = pins_s[0];
  assign tdi_s = pins_s[1];
  assign tap_state = state;
  assign nxt = tap_next(state, tms_s);
  // The DR shift path length follows the active instruction; BYPASS is one bit.
  always_comb begin
    is_id = ir_value == IR_IDCODE;
    is_user = ir_value == IR_USER;
    dr_cap = is_id ? IDCODE_VALUE : is_user ? 32'(user_dr_in) : 32'b0;
    dr_shift = is_id ? {tdi_s, dr_sr[31:1]}
             : is_user ? 32'({tdi_s, dr_sr[USER_DR_WIDTH-1:1]}) : {31'b0, tdi_s};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TLR;
      ir_value <= IR_IDCODE;
      ir_sr <= '0;
      dr_sr <= '0;
      tdo <= 1'b0;
      tdo_en <= 1'b0;
      user_dr_out <= '0;
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
      if (tck_rise) begin
        state <= nxt;
        if (state == TLR || nxt == TLR) ir_value <= IR_IDCODE;
        case (state)
          CAP_IR:   ir_sr <= IR_WIDTH'(IR_CAPTURE);
          SHIFT_IR: ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
          CAP_DR:   dr_sr <= dr_cap;
          SHIFT_DR: dr_sr <= dr_shift;
          default: ;
        endcase
      end
      // Output and update actions happen on the falling tck edge, as in 1149.1.
      if (tck_fall) begin
        tdo_en <= state == SHIFT_IR || state == SHIFT_DR;
        if (state == SHIFT_IR) tdo <= ir_sr[0];
        else if (state == SHIFT_DR) tdo <= dr_sr[0];
        if (state == UPD_IR) ir_value <= ir_sr;
        if (state == UPD_DR && is_user) begin
          user_dr_out <= dr_sr[USER_DR_WIDTH-1:0];
          user_dr_update <= 1'b1;
        end
      end
    end
  end
endmodule
